// File: rtl/sorted_result_mem.sv
// sorted_result_mem: collects Sorter writes with coverage/duplicate tracking,
// checks adjacent order in hardware after done, then drains in address order.
module sorted_result_mem #(
  parameter int DATA_WIDTH       = 32,
  parameter int ELEMENT_NUM      = 16,
  parameter int LOG2_ELEMENT_NUM = 4,
  parameter bit DESCEND          = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        SM_valid,
  input  logic [LOG2_ELEMENT_NUM-1:0] SM_addr,
  input  logic [DATA_WIDTH-1:0]       SM_data,
  input  logic                        done,
  input  logic                        rd_ready,
  output logic                        rd_valid,
  output logic [LOG2_ELEMENT_NUM-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic                        rd_last,
  output logic                        full,
  output logic                        dup_err,
  output logic                        late_err,
  output logic                        order_err,
  output logic                        check_done
);
  typedef enum logic [1:0] {COLLECT, CHECK, DRAIN, FINISH} state_t;
  localparam logic [LOG2_ELEMENT_NUM-1:0] ONE  = LOG2_ELEMENT_NUM'(1);
  localparam logic [LOG2_ELEMENT_NUM-1:0] LAST = LOG2_ELEMENT_NUM'(ELEMENT_NUM-1);
  localparam logic [LOG2_ELEMENT_NUM-1:0] PEN  = LOG2_ELEMENT_NUM'(ELEMENT_NUM-2);
  state_t                      state_q, state_d;
  logic [LOG2_ELEMENT_NUM-1:0] idx_q, idx_d, ptr_q, ptr_d, idx_n;
  logic [ELEMENT_NUM-1:0]      written_q, written_d;
  logic                        dup_q, dup_d, late_q, late_d, order_q, order_d, chk_q, chk_d, done_q;
  logic [DATA_WIDTH-1:0]       mem [ELEMENT_NUM];
  logic [DATA_WIDTH-1:0]       a, b;
  logic                        wr;
  assign idx_n = idx_q + ONE;
  // Unwritten locations behave as zero for both the order check and the drain.
  assign a  = written_q[idx_q] ? mem[idx_q] : '0;
  assign b  = written_q[idx_n] ? mem[idx_n] : '0;
  assign wr = !clr && state_q == COLLECT && SM_valid;
  assign rd_valid   = state_q == DRAIN;
  assign rd_addr    = ptr_q;
  assign rd_data    = rd_valid && written_q[ptr_q] ? mem[ptr_q] : '0;
  assign rd_last    = rd_valid && ptr_q == LAST;
  assign full       = &written_q;
  assign dup_err    = dup_q;
  assign late_err   = late_q;
  assign order_err  = order_q;
  assign check_done = chk_q;
  always_ff @(posedge clk)
    if (wr) mem[SM_addr] <= SM_data;
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    written_d = written_q;
    dup_d     = dup_q;
    late_d    = late_q;
    order_d   = order_q;
    chk_d     = chk_q;
    if (clr) begin
      state_d   = COLLECT;
      idx_d     = '0;
      ptr_d     = '0;
      written_d = '0;
      dup_d     = 1'b0;
      late_d    = 1'b0;
      order_d   = 1'b0;
      chk_d     = 1'b0;
    end else begin
      if (SM_valid && state_q != COLLECT) late_d = 1'b1;
      case (state_q)
        COLLECT: begin
          if (SM_valid) begin
            dup_d              = dup_q | written_q[SM_addr];
            written_d[SM_addr] = 1'b1;
          end
          if (done && !done_q) state_d = CHECK;
        end
        CHECK: begin
          if (DESCEND ? a < b : a > b) order_d = 1'b1;
          idx_d = idx_n;
          if (idx_q == PEN) begin
            state_d = DRAIN;
            chk_d   = 1'b1;
          end
        end
        DRAIN:
          if (rd_ready) begin
            ptr_d = ptr_q + ONE;
            if (ptr_q == LAST) state_d = FINISH;
          end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q   <= COLLECT;
      idx_q     <= '0;
      ptr_q     <= '0;
      written_q <= '0;
      dup_q     <= 1'b0;
      late_q    <= 1'b0;
      order_q   <= 1'b0;
      chk_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      written_q <= written_d;
      dup_q     <= dup_d;
      late_q    <= late_d;
      order_q   <= order_d;
      chk_q     <= chk_d;
      done_q    <= done;
    end
endmodule
